// File: rtl/perf_pkg.sv
// Shared encodings for the performance-counter controller: FSM states,
// display channel selects and the default counter width.
package perf_pkg;

    localparam int unsigned DEFAULT_DW = 32;

    localparam logic [1:0] CLR    = 2'd0;
    localparam logic [1:0] IDLE   = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] FROZEN = 2'd3;

    localparam logic [1:0] SEL_TOTAL = 2'd0;
    localparam logic [1:0] SEL_J     = 2'd1;
    localparam logic [1:0] SEL_JS    = 2'd2;
    localparam logic [1:0] SEL_LU    = 2'd3;

    // Display channel advance; 3 wraps to 0 through natural 2-bit overflow.
    function automatic logic [1:0] sel_advance(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/perf_counter_ctrl_if.sv
// Pipeline/counter/display signal bundle for perf_counter_ctrl.
// slave = the controller, master = pipeline, counter bank and display side.
interface perf_counter_ctrl_if
    import perf_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW
);
    logic          in_go;
    logic          in_halt;
    logic          in_clr;
    logic          in_next;
    logic          in_EN;
    logic          in_J;
    logic          in_JS;
    logic          in_loaduse;
    logic [DW-1:0] in_total;
    logic [DW-1:0] in_cntJ;
    logic [DW-1:0] in_cntJS;
    logic [DW-1:0] in_cntLU;
    logic          out_EN;
    logic          out_J;
    logic          out_JS;
    logic          out_loaduse;
    logic          out_RST;
    logic [1:0]    out_sel;
    logic [DW-1:0] out_disp;
    logic [1:0]    out_state;

    modport slave (
        input  in_go, in_halt, in_clr, in_next,
        input  in_EN, in_J, in_JS, in_loaduse,
        input  in_total, in_cntJ, in_cntJS, in_cntLU,
        output out_EN, out_J, out_JS, out_loaduse,
        output out_RST, out_sel, out_disp, out_state
    );

    modport master (
        output in_go, in_halt, in_clr, in_next,
        output in_EN, in_J, in_JS, in_loaduse,
        output in_total, in_cntJ, in_cntJS, in_cntLU,
        input  out_EN, out_J, out_JS, out_loaduse,
        input  out_RST, out_sel, out_disp, out_state
    );

endinterface

// File: rtl/perf_rotate_timer.sv
// FROZEN-state display auto-rotate timer; only built with PERF_AUTOROTATE_EN.
// Pulses out_tick every ROTATE_CYCLES enabled cycles; in_restart or !in_en zeroes it.
`ifdef PERF_AUTOROTATE_EN
module perf_rotate_timer #(
    parameter int unsigned ROTATE_CYCLES = 1024
) (
    input  logic in_CLK,
    input  logic in_RST_N,
    input  logic in_en,
    input  logic in_restart,
    output logic out_tick
);
    localparam int unsigned CW = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROTATE_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign out_tick = in_en && (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (!in_en || in_restart || out_tick) count_d = '0;
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) count_q <= '0;
        else           count_q <= count_d;
    end

endmodule
`endif

// File: rtl/perf_counter_ctrl.sv
// Run/freeze/clear controller and display mux for the performance-counter bank.
// Optional FROZEN-state display auto-rotate is enabled by defining PERF_AUTOROTATE_EN.
module perf_counter_ctrl
    import perf_pkg::*;
#(
    parameter int unsigned ROTATE_CYCLES = 1024,
    parameter int unsigned DW            = DEFAULT_DW
) (
    input  logic               in_CLK,
    input  logic               in_RST_N,
    perf_counter_ctrl_if.slave bus
);
    logic [1:0]         state_q, state_d;
    logic [1:0]         sel_q;
    logic [3:0][DW-1:0] snap_q;
    logic [DW-1:0]      live_val;
    logic               run, frozen, tick;

    assign run    = (state_q == RUN);
    assign frozen = (state_q == FROZEN);

    // Clear dominates everything; halt dominates go.
    always_comb begin
        state_d = state_q;
        if (bus.in_clr) begin
            state_d = CLR;
        end else begin
            case (state_q)
                CLR:     state_d = IDLE;
                IDLE:    if (bus.in_go) state_d = RUN;
                RUN:     if (bus.in_halt) state_d = FROZEN;
                FROZEN:  if (bus.in_go && !bus.in_halt) state_d = RUN;
                default: state_d = CLR;
            endcase
        end
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) state_q <= CLR;
        else           state_q <= state_d;
    end

    // Captured at the RUN->FROZEN edge, so strobes of the halt cycle are excluded.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            snap_q <= '0;
        end else if (state_q == CLR) begin
            snap_q <= '0;
        end else if (run && state_d == FROZEN) begin
            snap_q <= {bus.in_cntLU, bus.in_cntJS, bus.in_cntJ, bus.in_total};
        end
    end

`ifdef PERF_AUTOROTATE_EN
    perf_rotate_timer #(
        .ROTATE_CYCLES(ROTATE_CYCLES)
    ) u_rotate_timer (
        .in_CLK    (in_CLK),
        .in_RST_N  (in_RST_N),
        .in_en     (frozen),
        .in_restart(bus.in_next),
        .out_tick  (tick)
    );
`else
    logic unused_rotate;
    assign unused_rotate = ^ROTATE_CYCLES;
    assign tick          = 1'b0;
`endif

    // A manual advance coinciding with a timer tick still moves by one.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N)                sel_q <= SEL_TOTAL;
        else if (bus.in_next || tick) sel_q <= sel_advance(sel_q);
    end

    always_comb begin
        live_val = bus.in_total;
        case (sel_q)
            SEL_TOTAL: live_val = bus.in_total;
            SEL_J:     live_val = bus.in_cntJ;
            SEL_JS:    live_val = bus.in_cntJS;
            SEL_LU:    live_val = bus.in_cntLU;
            default:   live_val = bus.in_total;
        endcase
    end

    assign bus.out_EN      = run ? bus.in_EN : 1'b1;
    assign bus.out_J       = run & bus.in_J;
    assign bus.out_JS      = run & bus.in_JS;
    assign bus.out_loaduse = run & bus.in_loaduse;
    assign bus.out_RST     = (state_q == CLR);
    assign bus.out_sel     = sel_q;
    assign bus.out_disp    = frozen ? snap_q[sel_q] : live_val;
    assign bus.out_state   = state_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed table-driven bench for perf_counter_ctrl plus hand sequences for
// asynchronous reset and (with PERF_AUTOROTATE_EN) the auto-rotate timer.
module tb_perf_counter_ctrl;
    import perf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    perf_counter_ctrl_if #(.DW(32)) bus ();

    perf_counter_ctrl #(
        .ROTATE_CYCLES(4),
        .DW           (32)
    ) dut (
        .in_CLK  (clk),
        .in_RST_N(rst_n),
        .bus     (bus)
    );

    // ctl = {go, halt, clr, next}; ev = {EN, J, JS, loaduse}; g = gated {EN, J, JS, loaduse}
    typedef struct {
        logic [3:0]  ctl;
        logic [3:0]  ev;
        logic [31:0] total, cj, cjs, clu;
        logic [1:0]  st;
        logic        rst;
        logic [1:0]  sel;
        logic [3:0]  g;
        logic [31:0] disp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {bus.in_go, bus.in_halt, bus.in_clr, bus.in_next} = v.ctl;
        {bus.in_EN, bus.in_J, bus.in_JS, bus.in_loaduse}  = v.ev;
        bus.in_total = v.total;
        bus.in_cntJ  = v.cj;
        bus.in_cntJS = v.cjs;
        bus.in_cntLU = v.clu;
    endtask

    function automatic logic [31:0] gated();
        return 32'({bus.out_EN, bus.out_J, bus.out_JS, bus.out_loaduse});
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(vec_t'{4'b0000, 4'b0111, 5,   0,  0,  0,  CLR,    1'b1, 2'd0, 4'b1000, 5});
        vecs.push_back(vec_t'{4'b0100, 4'b0100, 6,   0,  0,  0,  IDLE,   1'b0, 2'd0, 4'b1000, 6});
        vecs.push_back(vec_t'{4'b1000, 4'b0100, 7,   0,  0,  0,  IDLE,   1'b0, 2'd0, 4'b1000, 7});
        vecs.push_back(vec_t'{4'b0000, 4'b1110, 8,   1,  1,  0,  RUN,    1'b0, 2'd0, 4'b1110, 8});
        vecs.push_back(vec_t'{4'b0000, 4'b0001, 9,   1,  1,  1,  RUN,    1'b0, 2'd0, 4'b0001, 9});
        vecs.push_back(vec_t'{4'b0001, 4'b1000, 10,  1,  1,  1,  RUN,    1'b0, 2'd0, 4'b1000, 10});
        vecs.push_back(vec_t'{4'b0000, 4'b1100, 11,  9,  1,  1,  RUN,    1'b0, 2'd1, 4'b1100, 9});
        vecs.push_back(vec_t'{4'b1100, 4'b1100, 100, 10, 7,  3,  RUN,    1'b0, 2'd1, 4'b1100, 10});
        vecs.push_back(vec_t'{4'b0000, 4'b0111, 101, 99, 8,  4,  FROZEN, 1'b0, 2'd1, 4'b1000, 10});
        vecs.push_back(vec_t'{4'b0001, 4'b0000, 102, 99, 8,  4,  FROZEN, 1'b0, 2'd1, 4'b1000, 10});
        vecs.push_back(vec_t'{4'b0000, 4'b0000, 103, 99, 55, 4,  FROZEN, 1'b0, 2'd2, 4'b1000, 7});
        vecs.push_back(vec_t'{4'b0001, 4'b0000, 103, 99, 55, 4,  FROZEN, 1'b0, 2'd2, 4'b1000, 7});
        vecs.push_back(vec_t'{4'b0001, 4'b0000, 103, 99, 55, 77, FROZEN, 1'b0, 2'd3, 4'b1000, 3});
        vecs.push_back(vec_t'{4'b0000, 4'b0000, 500, 99, 55, 77, FROZEN, 1'b0, 2'd0, 4'b1000, 100});
        vecs.push_back(vec_t'{4'b1100, 4'b0000, 500, 99, 55, 77, FROZEN, 1'b0, 2'd0, 4'b1000, 100});
        vecs.push_back(vec_t'{4'b1000, 4'b0000, 500, 99, 55, 77, FROZEN, 1'b0, 2'd0, 4'b1000, 100});
        vecs.push_back(vec_t'{4'b0001, 4'b1101, 500, 99, 55, 77, RUN,    1'b0, 2'd0, 4'b1101, 500});
        vecs.push_back(vec_t'{4'b0111, 4'b1111, 510, 20, 30, 40, RUN,    1'b0, 2'd1, 4'b1111, 20});
        vecs.push_back(vec_t'{4'b0010, 4'b0100, 510, 20, 30, 40, CLR,    1'b1, 2'd2, 4'b1000, 30});
        vecs.push_back(vec_t'{4'b1000, 4'b0100, 510, 20, 30, 40, CLR,    1'b1, 2'd2, 4'b1000, 30});
        vecs.push_back(vec_t'{4'b0000, 4'b0000, 510, 20, 30, 40, IDLE,   1'b0, 2'd2, 4'b1000, 30});

        // Reset values while in_RST_N is held low.
        drive(vecs[0]);
        #2;
        check("reset state", 32'(bus.out_state), 32'(CLR));
        check("reset out_RST", 32'(bus.out_RST), 1);
        check("reset out_sel", 32'(bus.out_sel), 0);
        check("reset gated", gated(), 32'h8);
        check("reset out_disp", bus.out_disp, 5);
        #10;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d state", i), 32'(bus.out_state), 32'(vecs[i].st));
            check($sformatf("v%0d out_RST", i), 32'(bus.out_RST), 32'(vecs[i].rst));
            check($sformatf("v%0d out_sel", i), 32'(bus.out_sel), 32'(vecs[i].sel));
            check($sformatf("v%0d gated", i), gated(), 32'(vecs[i].g));
            check($sformatf("v%0d out_disp", i), bus.out_disp, vecs[i].disp);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a RUN cycle.
        bus.in_go = 1'b1;
        cyc();
        check("pre-reset state", 32'(bus.out_state), 32'(RUN));
        bus.in_go    = 1'b0;
        bus.in_J     = 1'b1;
        bus.in_total = 777;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset state", 32'(bus.out_state), 32'(CLR));
        check("async reset out_RST", 32'(bus.out_RST), 1);
        check("async reset out_sel", 32'(bus.out_sel), 0);
        check("async reset gated", gated(), 32'h8);
        check("async reset out_disp", bus.out_disp, 777);
        #3;
        rst_n = 1'b1;
        cyc();
        check("post-reset state", 32'(bus.out_state), 32'(IDLE));
        check("post-reset out_RST", 32'(bus.out_RST), 0);

        // Enter FROZEN with sel=0 and a known total.
        bus.in_go = 1'b1;
        cyc();
        bus.in_go    = 1'b0;
        bus.in_halt  = 1'b1;
        bus.in_total = 1234;
        cyc();
        bus.in_halt  = 1'b0;
        bus.in_total = 4321;
        check("frozen entry state", 32'(bus.out_state), 32'(FROZEN));
        check("frozen snapshot total", bus.out_disp, 1234);

`ifdef PERF_AUTOROTATE_EN
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rot hold0 c%0d", k), 32'(bus.out_sel), 0);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rot hold1 c%0d", k), 32'(bus.out_sel), 1);
            cyc();
        end
        bus.in_next = 1'b1;
        check("rot tick+next before", 32'(bus.out_sel), 1);
        cyc();
        bus.in_next = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rot hold2 c%0d", k), 32'(bus.out_sel), 2);
            cyc();
        end
        check("rot after restart", 32'(bus.out_sel), 3);
`else
        for (int k = 0; k < 10; k++) begin
            check($sformatf("no-rotate hold c%0d", k), 32'(bus.out_sel), 0);
            cyc();
        end
        bus.in_next = 1'b1;
        cyc();
        bus.in_next = 1'b0;
        check("no-rotate manual next", 32'(bus.out_sel), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

Run/freeze/clear controller and readout multiplexer for the pipeline performance-counter bank. It sits between the CPU pipeline (halt, stall and hazard events) and the four-channel event counter: total cycles, jumps, taken branches and load-use stalls. It gates event strobes so counts accumulate only while the program runs. It snapshots all four counts when the CPU halts and selects one 32-bit value for the board display.

## Interface
- ROTATE_CYCLES, 1024: FROZEN-state cycles per automatic display advance; only used with PERF_AUTOROTATE_EN.
- DW, 32: counter value width.

- in_CLK  in  1  clock; all state changes on rising edge.
- in_RST_N  in  1  reset; asynchronous, active-low.
- in_go  in  1  start/resume request, level.
- in_halt  in  1  halt instruction retired, level.
- in_clr  in  1  clear request from user switch, level.
- in_next  in  1  display advance; one-cycle pulse, already debounced.
- in_EN, in_J, in_JS, in_loaduse  in  1 each  raw pipeline enable and event strobes.
- in_total, in_cntJ, in_cntJS, in_cntLU  in  DW each  live counter values.
- out_EN, out_J, out_JS, out_loaduse  out  1 each  gated strobes to the counter.
- out_RST  out  1  synchronous clear to the counter, active-high.
- out_sel  out  2  display channel: 0 total, 1 J, 2 JS, 3 loaduse.
- out_disp  out  DW  selected value.
- out_state  out  2  FSM state encoding.

## Operation
- States: CLR=0, IDLE=1, RUN=2, FROZEN=3.
- Reset state is CLR, so the counter is cleared on the first clock after reset release.
- Transition priority is in_clr > in_halt > in_go.
  - Any state with in_clr=1 goes to CLR. CLR holds while in_clr stays 1.
  - CLR with in_clr=0 goes to IDLE after exactly one cycle.
  - IDLE with in_go goes to RUN. in_halt is ignored in IDLE.
  - RUN with in_halt goes to FROZEN. in_halt together with in_go also goes to FROZEN.
  - FROZEN with in_go and no in_halt goes to RUN. Counts are preserved; no clear.
- out_RST=1 iff state==CLR.
- In RUN, out_EN=in_EN, out_J=in_J, out_JS=in_JS and out_loaduse=in_loaduse.
- In all other states, out_J, out_JS and out_loaduse are 0 and out_EN is 1.
- Snapshot: four DW registers load in_total, in_cntJ, in_cntJS and in_cntLU on the RUN->FROZEN edge. They clear to 0 in CLR.
- out_disp shows the snapshot[out_sel] in FROZEN and the live value[out_sel] in every other state.
- in_next advances out_sel by 1 modulo 4 (3 wraps to 0) in any state. out_sel is not changed by CLR.

## Timing
- Gated strobes, out_RST and out_disp are combinational from the registered state and inputs, with zero latency.
- The snapshot captures the counter values present at the halt edge. Events strobed in the halt cycle are not included.
- Reset values:
  - state=CLR, out_RST=1, out_sel=0, snapshots=0, rotate timer=0.
  - Gated strobes are 0 and out_EN=1.
  - out_disp=in_total.
- An asynchronous reset during RUN or FROZEN discards the snapshots immediately.

## Configuration
- PERF_AUTOROTATE_EN defined:
  - In FROZEN, a timer counts cycles. When it reaches ROTATE_CYCLES-1, out_sel advances and the timer returns to 0.
  - in_next or leaving FROZEN zeroes the timer.
  - in_next coinciding with a timer tick advances out_sel by 1 only.
- PERF_AUTOROTATE_EN undefined: no timer is built, out_sel changes only on in_next, and ROTATE_CYCLES is ignored.

## Structure
- Shared package perf_pkg holds:
  - state encodings CLR, IDLE, RUN and FROZEN;
  - SEL_TOTAL=0, SEL_J=1, SEL_JS=2, SEL_LU=3;
  - the default DW.
- Sub-module perf_rotate_timer (the ROTATE_CYCLES timer) is instantiated only under PERF_AUTOROTATE_EN.

## Test plan
- Reset release -> out_RST=1 for 1 cycle, then IDLE. In IDLE, in_J=1 gives out_J=0.
- in_go, then 10 cycles of in_J=1 -> out_J=1 for those 10 cycles. in_halt with in_cntJ=10 -> FROZEN; out_sel=1 gives out_disp=10 while in_cntJ changes to 99.
- FROZEN: in_next pulsed 4 times -> out_sel goes 1,2,3,0. in_go -> RUN with live out_disp.
- in_clr and in_halt asserted together in RUN -> CLR for 1 cycle, snapshots=0, then IDLE.
- With PERF_AUTOROTATE_EN and ROTATE_CYCLES=4 in FROZEN -> out_sel advances every 4 cycles. in_next in the same cycle as a tick -> a single advance.
- in_RST_N pulsed low mid-RUN, away from the clock edge -> outputs take reset values immediately.
